// File: rtl/coded_mac_pkg.sv
// Shared types and helpers for the coded multiply-accumulate datapath.
package coded_mac_pkg;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int SAT_W = 64;

    function automatic int calc_idx_w(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    // Coefficient width includes a sign bit so the multiply can stay fully signed.
    function automatic int calc_cw(input int num_words, input int coef_base);
        return $clog2(num_words + coef_base) + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] prod,
        input int                      acc_w
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] sum;
        max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (acc_w - 1));
        sum   = acc + prod;
        if (sum > max_v) begin
            sum = max_v;
        end else if (sum < min_v) begin
            sum = min_v;
        end
        return sum;
    endfunction

    function automatic logic sat_hit(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] prod,
        input int                      acc_w
    );
        logic signed [SAT_W-1:0] sum;
        sum = acc + prod;
        return (sum > ((64'sd1 <<< (acc_w - 1)) - 64'sd1)) || (sum < -(64'sd1 <<< (acc_w - 1)));
    endfunction

endpackage

// File: rtl/coded_mac_lane.sv
// One lane: registered coded product, then saturating accumulate with sticky overflow.
module coded_mac_lane
    import coded_mac_pkg::*;
#(
    parameter int LANE_W = 16,
    parameter int CW     = 5,
    parameter int ACC_W  = 22
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_accept,
    input  logic              i_bad,
    input  logic              i_drain,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [CW-1:0]     i_coef,
    output logic [ACC_W-1:0]  o_acc_final,
    output logic              o_ovf_final
);

    localparam int PROD_W = LANE_W + CW;

    logic signed [PROD_W-1:0] r_prod;
    logic                     r_prod_vld;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_ovf_acc;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic                     w_ovf_next;

    always_comb begin
        w_prod = '0;
        if (!i_bad) begin
            w_prod = PROD_W'(signed'(i_lane)) * signed'(PROD_W'(i_coef));
        end
    end

    always_comb begin
        w_acc_next = r_acc;
        w_ovf_next = r_ovf_acc;
        if (r_prod_vld) begin
            w_acc_next = ACC_W'(sat_add(SAT_W'(r_acc), SAT_W'(r_prod), ACC_W));
            w_ovf_next = r_ovf_acc | sat_hit(SAT_W'(r_acc), SAT_W'(r_prod), ACC_W);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            r_ovf_acc  <= 1'b0;
        end else begin
            r_prod_vld <= i_accept;
            if (i_accept) begin
                r_prod <= w_prod;
            end
            // The drain cycle hands the final sum to the top and restarts the frame.
            if (i_drain) begin
                r_acc     <= '0;
                r_ovf_acc <= 1'b0;
            end else begin
                r_acc     <= w_acc_next;
                r_ovf_acc <= w_ovf_next;
            end
        end
    end

    assign o_acc_final = w_acc_next;
    assign o_ovf_final = w_ovf_next;

endmodule

// File: rtl/coded_mac_accum.sv
// Multi-lane coded MAC: beat handshake, word select, per-lane accumulate, held result.
//   state | meaning
//   ACC   | accepting beats, accumulating products
//   DRAIN | last product in flight, result loads at end of this cycle
//   HOLD  | result valid, waiting for out_ready
module coded_mac_accum
    import coded_mac_pkg::*;
#(
    parameter int NUM_WORDS = 8,
    parameter int LANES     = 2,
    parameter int LANE_W    = 16,
    parameter int ACC_W     = 22,
    parameter int COEF_BASE = 1,
    localparam int IDX_W    = calc_idx_w(NUM_WORDS),
    localparam int CW       = calc_cw(NUM_WORDS, COEF_BASE)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic [IDX_W-1:0]                index,
    input  logic [NUM_WORDS*LANES*LANE_W-1:0] data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*ACC_W-1:0]          res,
    output logic [LANES-1:0]                ovf,
    output logic                            idx_err
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_rst_done;
    logic                     r_idx_err_acc;
    logic [LANES*ACC_W-1:0]   r_res;
    logic [LANES-1:0]         r_ovf;
    logic                     r_idx_err;

    logic                     w_accept;
    logic                     w_drain;
    logic                     w_idx_ok;
    logic [IDX_W-1:0]         w_sel;
    logic [CW-1:0]            w_coef;
    logic [LANES*ACC_W-1:0]   w_acc_final;
    logic [LANES-1:0]         w_ovf_final;

    assign in_ready  = (r_state == ACC) && r_rst_done;
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = (r_state == DRAIN);

    // Out-of-range indices select word 0 only to keep the mux in range; the product is zeroed.
    assign w_idx_ok = (int'(index) < NUM_WORDS);
    assign w_sel    = w_idx_ok ? index : '0;
    assign w_coef   = CW'(w_sel) + CW'(COEF_BASE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACC:     if (w_accept && in_last) w_state_next = DRAIN;
            DRAIN:   w_state_next = HOLD;
            HOLD:    if (out_ready) w_state_next = ACC;
            default: w_state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ACC;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rst_done <= 1'b1;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LANE_W-1:0] w_lane;
        assign w_lane = data[(int'(w_sel) * LANES + k) * LANE_W +: LANE_W];

        coded_mac_lane #(
            .LANE_W (LANE_W),
            .CW     (CW),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk         (clk),
            .rstn        (rstn),
            .i_accept    (w_accept),
            .i_bad       (!w_idx_ok),
            .i_drain     (w_drain),
            .i_lane      (w_lane),
            .i_coef      (w_coef),
            .o_acc_final (w_acc_final[k*ACC_W +: ACC_W]),
            .o_ovf_final (w_ovf_final[k])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx_err_acc <= 1'b0;
            r_res         <= '0;
            r_ovf         <= '0;
            r_idx_err     <= 1'b0;
        end else begin
            if (w_drain) begin
                r_idx_err_acc <= 1'b0;
                r_res         <= w_acc_final;
                r_ovf         <= w_ovf_final;
                r_idx_err     <= r_idx_err_acc;
            end else if (w_accept && !w_idx_ok) begin
                r_idx_err_acc <= 1'b1;
            end
        end
    end

    assign res     = r_res;
    assign ovf     = r_ovf;
    assign idx_err = r_idx_err;

endmodule

// File: tb/tb_coded_mac_accum.sv
// Randomized bench for coded_mac_accum against a plain-arithmetic frame model (8- and 6-word instances).
module tb_coded_mac_accum;

    localparam int NW     = 8;
    localparam int NW6    = 6;
    localparam int LANES  = 2;
    localparam int LANE_W = 16;
    localparam int ACC_W  = 22;
    localparam int DW     = NW * LANES * LANE_W;
    localparam int DW6    = NW6 * LANES * LANE_W;
    localparam int RW     = LANES * ACC_W;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [2:0]    index;
    logic [DW-1:0] data;

    logic          in_ready,  in_ready_6;
    logic          out_valid, out_valid_6;
    logic [RW-1:0] res,       res_6;
    logic [1:0]    ovf,       ovf_6;
    logic          idx_err,   idx_err_6;

    int n_checks = 0;
    int n_errors = 0;

    int q_idx[$];
    int q_l0[$];
    int q_l1[$];

    coded_mac_accum #(.NUM_WORDS(NW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .index(index), .data(data), .out_valid(out_valid),
        .out_ready(out_ready), .res(res), .ovf(ovf), .idx_err(idx_err)
    );

    coded_mac_accum #(.NUM_WORDS(NW6)) dut6 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_6),
        .in_last(in_last), .index(index), .data(data[DW6-1:0]), .out_valid(out_valid_6),
        .out_ready(out_ready), .res(res_6), .ovf(ovf_6), .idx_err(idx_err_6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame result from the rules: sum of signed lane * (index+1), clamped per add.
    task automatic model(input int nw, output logic [RW-1:0] e_res, output logic [1:0] e_ovf,
                         output logic e_err);
        longint acc[LANES];
        longint v;
        longint hi, lo;
        hi = (longint'(1) << (ACC_W - 1)) - 1;
        lo = -(longint'(1) << (ACC_W - 1));
        e_ovf = '0;
        e_err = 1'b0;
        for (int k = 0; k < LANES; k++) acc[k] = 0;
        for (int i = 0; i < q_idx.size(); i++) begin
            if (q_idx[i] >= nw) begin
                e_err = 1'b1;
            end else begin
                for (int k = 0; k < LANES; k++) begin
                    v = (k == 0) ? longint'(q_l0[i]) : longint'(q_l1[i]);
                    if (v >= 32768) v = v - 65536;
                    acc[k] = acc[k] + v * (q_idx[i] + 1);
                    if (acc[k] > hi) begin acc[k] = hi; e_ovf[k] = 1'b1; end
                    if (acc[k] < lo) begin acc[k] = lo; e_ovf[k] = 1'b1; end
                end
            end
        end
        for (int k = 0; k < LANES; k++) e_res[k*ACC_W +: ACC_W] = ACC_W'(acc[k]);
    endtask

    task automatic add_beat(input int idx, input int l0, input int l1);
        q_idx.push_back(idx);
        q_l0.push_back(l0);
        q_l1.push_back(l1);
    endtask

    task automatic clear_q();
        q_idx.delete();
        q_l0.delete();
        q_l1.delete();
    endtask

    task automatic junk_inputs(input logic vld);
        for (int w = 0; w < DW / 32; w++) data[w*32 +: 32] = $urandom();
        index    = 3'($urandom_range(0, 7));
        in_last  = 1'($urandom_range(0, 1));
        in_valid = vld;
    endtask

    task automatic send_beats(input int bubble_mode, input bit with_last);
        int budget;
        for (int i = 0; i < q_idx.size(); i++) begin
            if ((bubble_mode == 1 && i > 0) || (bubble_mode == 2 && $urandom_range(0, 2) == 0)) begin
                junk_inputs(1'b0);
                @(posedge clk); #1;
            end
            junk_inputs(1'b1);
            data[(q_idx[i]*2)*16 +: 16]   = 16'(q_l0[i]);
            data[(q_idx[i]*2+1)*16 +: 16] = 16'(q_l1[i]);
            index   = 3'(q_idx[i]);
            in_last = with_last && (i == q_idx.size() - 1);
            budget  = 0;
            while (!in_ready && budget < 20) begin
                @(posedge clk); #1;
                budget++;
            end
            check("beat_ready", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_frame(input int hold_cycles);
        logic [RW-1:0] e_res, e_res6;
        logic [1:0]    e_ovf, e_ovf6;
        logic          e_err, e_err6;
        model(NW, e_res, e_ovf, e_err);
        model(NW6, e_res6, e_ovf6, e_err6);
        check("drain_out_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("out_valid_n2", out_valid, 1);
        check("out_valid6_n2", out_valid_6, 1);
        check("res_lane0", res[ACC_W-1:0], e_res[ACC_W-1:0]);
        check("res_lane1", res[RW-1:ACC_W], e_res[RW-1:ACC_W]);
        check("ovf", ovf, e_ovf);
        check("idx_err", idx_err, e_err);
        check("res6", res_6, e_res6);
        check("ovf6", ovf_6, e_ovf6);
        check("idx_err6", idx_err_6, e_err6);
        for (int h = 0; h < hold_cycles; h++) begin
            junk_inputs(1'b1);
            @(posedge clk); #1;
            check("hold_res", res, e_res);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("rel_out_valid", out_valid, 0);
        check("rel_in_ready", in_ready, 1);
        check("kept_res", res, e_res);
        clear_q();
    endtask

    task automatic basic_frame_q();
        for (int i = 0; i < 8; i++) add_beat(i, 16'h0001, 16'hFFFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, heavy, v;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        index     = '0;
        data      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res", res, 0);
        check("rst_ovf", ovf, 0);
        check("rst_idx_err", idx_err, 0);
        rstn = 1'b1;
        check("rel_first_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("in_ready_up", in_ready, 1);

        basic_frame_q();
        send_beats(0, 1'b1);
        finish_frame(0);
        check("basic_lane0", res[ACC_W-1:0], 22'd36);
        check("basic_lane1", res[RW-1:ACC_W], 22'h3FFFDC);

        for (int i = 0; i < 16; i++) add_beat(7, 16'h7FFF, 0);
        send_beats(0, 1'b1);
        finish_frame(0);
        check("sat_lane0", res[ACC_W-1:0], 22'h1FFFFF);
        check("sat_ovf", ovf, 2'b01);
        add_beat(0, 5, 0);
        send_beats(0, 1'b1);
        finish_frame(0);
        check("post_sat_lane0", res[ACC_W-1:0], 22'd5);
        check("post_sat_ovf", ovf, 2'b00);

        basic_frame_q();
        send_beats(0, 1'b1);
        finish_frame(5);

        basic_frame_q();
        send_beats(1, 1'b1);
        finish_frame(0);
        check("bubble_lane0", res[ACC_W-1:0], 22'd36);

        add_beat(0, 16'h0002, 0);
        add_beat(6, 16'h0002, 0);
        send_beats(0, 1'b1);
        finish_frame(0);
        check("badidx6_lane0", res_6[ACC_W-1:0], 22'd2);
        check("badidx6_err", idx_err_6, 1);
        check("badidx8_err", idx_err, 0);

        for (int i = 0; i < 4; i++) add_beat(i, 16'h0001, 16'hFFFF);
        send_beats(0, 1'b0);
        rstn = 1'b0;
        #1;
        check("midrst_res", res, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_idx_err", idx_err, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        clear_q();
        basic_frame_q();
        send_beats(0, 1'b1);
        finish_frame(0);
        check("after_rst_lane0", res[ACC_W-1:0], 22'd36);

        for (int f = 0; f < 14; f++) begin
            heavy = $urandom_range(0, 3);
            nb    = (heavy == 0) ? 12 : $urandom_range(1, 10);
            for (int i = 0; i < nb; i++) begin
                if (heavy == 0) begin
                    v = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
                    add_beat(7, v, 16'h8000);
                end else begin
                    add_beat($urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(0, 65535));
                end
            end
            send_beats(2, 1'b1);
            finish_frame($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
